hog_frame_ctrl: RTL

HOG_FRAME_CTRL -- requirements
Module: hog_frame_ctrl

---
 rtl/hog_pkg.sv | 24 ++
 rtl/hog_frame_ctrl_if.sv | 12 +
 rtl/hog_addr_gen.sv | 62 ++++++
 rtl/hog_frame_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/hog_pkg.sv
// Shared constants and encodings for the HOG frame controller slice.
package hog_pkg;
    localparam int PIX_W_DEF     = 8;
    localparam int IMG_W_DEF     = 128;
    localparam int IMG_H_DEF     = 64;
    localparam int ADDR_W_DEF    = 13;
    localparam int FEA_W_DEF     = 12;
    localparam int FEA_TOTAL_DEF = 3780;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } hog_state_e;

    // Neighbour read order per center pixel; also the hog_data packing order.
    typedef enum logic [1:0] {
        NB_LEFT   = 2'd0,
        NB_RIGHT  = 2'd1,
        NB_TOP    = 2'd2,
        NB_BOTTOM = 2'd3
    } hog_nb_e;
endpackage

// File: rtl/hog_frame_ctrl_if.sv
// Frame-memory read bus: strobe + address out, data back one cycle later.
interface hog_frame_ctrl_if #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 13
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_rd_data;

    modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);
endinterface

// File: rtl/hog_addr_gen.sv
// Raster walk over center pixels, four clamped neighbour reads per pixel.
module hog_addr_gen
    import hog_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output hog_nb_e           slot,
    output logic              last
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [XW-1:0] x, nx;
    logic [YW-1:0] y, ny;
    logic          x_end, y_end;

    assign x_end = (x == XW'(IMG_W - 1));
    assign y_end = (y == YW'(IMG_H - 1));
    assign last  = (slot == NB_BOTTOM) && x_end && y_end;

    // Stepping past the final read wraps to (0,0) so IDLE always sees address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            slot <= NB_LEFT;
        end else if (step) begin
            if (slot != NB_BOTTOM) begin
                slot <= hog_nb_e'(slot + 2'd1);
            end else begin
                slot <= NB_LEFT;
                if (x_end) begin
                    x <= '0;
                    y <= y_end ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Border pixels replicate: out-of-frame neighbours clamp to the edge.
    always_comb begin
        nx = x;
        ny = y;
        case (slot)
            NB_LEFT:   if (x != '0) nx = x - 1'b1;
            NB_RIGHT:  if (!x_end)  nx = x + 1'b1;
            NB_TOP:    if (y != '0) ny = y - 1'b1;
            NB_BOTTOM: if (!y_end)  ny = y + 1'b1;
            default:   ;
        endcase
    end

    assign addr = ADDR_W'(ny) * ADDR_W'(IMG_W) + ADDR_W'(nx);
endmodule

// File: rtl/hog_frame_ctrl.sv
// Frame sequencer: streams neighbour quads into the HOG pipeline and
// forwards/counts the returning features until the frame is complete.
module hog_frame_ctrl
    import hog_pkg::*;
#(
    parameter int PIX_W     = PIX_W_DEF,
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int FEA_W     = FEA_W_DEF,
    parameter int FEA_TOTAL = FEA_TOTAL_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    hog_frame_ctrl_if.master                 mem,
    output logic                             hog_valid,
    output logic [4*PIX_W-1:0]               hog_data,
    input  logic [FEA_W-1:0]                 fea_in,
    input  logic                             fea_in_valid,
    output logic [FEA_W-1:0]                 fea_out,
    output logic                             fea_out_valid,
    output logic [$clog2(FEA_TOTAL+1)-1:0]   fea_idx,
    output logic                             frame_done
);
    localparam int FIDX_W = $clog2(FEA_TOTAL + 1);

    hog_state_e        state, state_nxt;
    logic [ADDR_W-1:0] gen_addr;
    hog_nb_e           gen_slot, rd_slot_d;
    logic              gen_last, fetch, fwd, rd_vld_d;
    logic [PIX_W-1:0]  pix_l, pix_r, pix_t;
    logic [FIDX_W-1:0] cnt;

    hog_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .step (fetch),
        .addr (gen_addr),
        .slot (gen_slot),
        .last (gen_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        fetch          = 1'b0;
        fwd            = 1'b0;
        busy           = 1'b1;
        frame_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                fetch = 1'b1;
                fwd   = 1'b1;
                if (gen_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                fwd = 1'b1;
                if (cnt == FIDX_W'(FEA_TOTAL)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem.mem_rd_en = fetch;
    assign mem.mem_addr  = fetch ? gen_addr : '0;

    // Read data lands one cycle after its strobe; the slot tag travels with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_d  <= 1'b0;
            rd_slot_d <= NB_LEFT;
            pix_l     <= '0;
            pix_r     <= '0;
            pix_t     <= '0;
            hog_valid <= 1'b0;
            hog_data  <= '0;
        end else begin
            rd_vld_d  <= fetch;
            rd_slot_d <= gen_slot;
            hog_valid <= 1'b0;
            if (rd_vld_d) begin
                case (rd_slot_d)
                    NB_LEFT:   pix_l <= mem.mem_rd_data;
                    NB_RIGHT:  pix_r <= mem.mem_rd_data;
                    NB_TOP:    pix_t <= mem.mem_rd_data;
                    NB_BOTTOM: begin
                        hog_data  <= {pix_l, pix_r, pix_t, mem.mem_rd_data};
                        hog_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Features past FEA_TOTAL are still forwarded but no longer counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fea_out       <= '0;
            fea_out_valid <= 1'b0;
            fea_idx       <= '0;
            cnt           <= '0;
        end else begin
            fea_out_valid <= fwd && fea_in_valid;
            if (state == ST_IDLE && start) begin
                fea_idx <= '0;
                cnt     <= '0;
            end else if (fwd && fea_in_valid) begin
                fea_out <= fea_in;
                fea_idx <= cnt;
                if (cnt != FIDX_W'(FEA_TOTAL)) cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
